// File: rtl/msb_seek_engine_if.sv
// msb_seek_engine_if: producer/consumer handshake bundle for msb_seek_engine.
//   in_valid/in_ready/in_data/in_mode    : word offered for search
//   out_valid/out_ready/out_index/out_zero : search result
// slave = engine side, master = producer/consumer side.
interface msb_seek_engine_if #(
  parameter int DATA_WIDTH = 23
);
  localparam int IDX_W = $clog2(DATA_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDX_W-1:0]      out_index;
  logic                  out_zero;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_index, out_zero
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_index, out_zero
  );
endinterface

// File: rtl/msb_seek_engine.sv
// msb_seek_engine: iterative leading/trailing-one locator.
// Captures a word on the input handshake, binary-searches it for the highest
// (in_mode=0) or lowest (in_mode=1) set bit in $clog2(DATA_WIDTH) cycles, and
// holds the result until the output handshake.
// Ports:
//   clk    : clock, rising edge
//   nRESET : asynchronous active-low reset
//   bus    : msb_seek_engine_if.slave (input and output handshakes)
//   busy_o : high whenever the engine is not idle
module msb_seek_engine #(
  parameter int DATA_WIDTH = 23
) (
  input  logic                   clk,
  input  logic                   nRESET,
  msb_seek_engine_if.slave       bus,
  output logic                   busy_o
);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam int P     = 1 << IDX_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]       state_q;
  logic [P-1:0]     data_q;
  logic             mode_q;
  logic [IDX_W:0]   lo_q;
  logic [IDX_W:0]   size_q;
  logic [IDX_W:0]   cnt_q;
  logic [IDX_W-1:0] index_q;
  logic             zero_q;

  logic [IDX_W:0]   half;
  logic [IDX_W:0]   lo_next;
  logic [P-1:0]     window;
  logic [P-1:0]     low_mask;
  logic             hi_any;
  logic             lo_any;

  // Align the current window to bit 0, then test its lower and upper halves.
  // Masking with low_mask keeps bits beyond lo+size out of the decision.
  always_comb begin
    half     = size_q >> 1;
    window   = data_q >> lo_q;
    low_mask = (P'(1) << half) - P'(1);
    hi_any   = |((window >> half) & low_mask);
    lo_any   = |(window & low_mask);
    lo_next  = lo_q;
    if (mode_q ? !lo_any : hi_any) lo_next = lo_q + half;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      data_q  <= '0;
      mode_q  <= 1'b0;
      lo_q    <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      index_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            data_q <= P'(bus.in_data);
            mode_q <= bus.in_mode;
            lo_q   <= '0;
            size_q <= (IDX_W+1)'(P);
            cnt_q  <= '0;
            if (bus.in_data == '0) begin
              index_q <= '0;
              zero_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= SEARCH;
            end
          end
        end
        SEARCH: begin
          lo_q   <= lo_next;
          size_q <= half;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == (IDX_W+1)'(IDX_W-1)) begin
            index_q <= lo_next[IDX_W-1:0];
            zero_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = nRESET && (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_index = index_q;
  assign bus.out_zero  = zero_q;
  assign busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_msb_seek_engine.sv
// tb_msb_seek_engine: directed bench for msb_seek_engine at DATA_WIDTH=23
// (dut_a, IDX_W=5) and DATA_WIDTH=16 (dut_b, IDX_W=4).
module tb_msb_seek_engine;
  logic clk = 1'b0;
  logic nRESET;
  logic busy_a, busy_b;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  msb_seek_engine_if #(.DATA_WIDTH(23)) ifa ();
  msb_seek_engine_if #(.DATA_WIDTH(16)) ifb ();

  msb_seek_engine #(.DATA_WIDTH(23)) dut_a (
    .clk(clk), .nRESET(nRESET), .bus(ifa.slave), .busy_o(busy_a)
  );
  msb_seek_engine #(.DATA_WIDTH(16)) dut_b (
    .clk(clk), .nRESET(nRESET), .bus(ifb.slave), .busy_o(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic get(input bit w, output logic ov, output logic ir, output logic bz,
                     output logic [4:0] idx, output logic z);
    if (w) begin
      ov = ifb.out_valid; ir = ifb.in_ready; bz = busy_b;
      idx = {1'b0, ifb.out_index}; z = ifb.out_zero;
    end else begin
      ov = ifa.out_valid; ir = ifa.in_ready; bz = busy_a;
      idx = ifa.out_index; z = ifa.out_zero;
    end
  endtask

  task automatic check_outs(input bit w, input string tag, input logic ov_e, input logic ir_e,
                            input logic bz_e, input logic [4:0] idx_e, input logic z_e);
    logic ov, ir, bz, z;
    logic [4:0] idx;
    get(w, ov, ir, bz, idx, z);
    check({tag, "_out_valid"}, 32'(ov), 32'(ov_e));
    check({tag, "_in_ready"}, 32'(ir), 32'(ir_e));
    check({tag, "_busy"}, 32'(bz), 32'(bz_e));
    check({tag, "_out_index"}, 32'(idx), 32'(idx_e));
    check({tag, "_out_zero"}, 32'(z), 32'(z_e));
  endtask

  // Offer a word; returns one cycle after the accepting edge (cycle T+1).
  task automatic launch(input bit w, input logic [22:0] d, input logic m, input string tag);
    logic ov, ir, bz, z;
    logic [4:0] idx;
    get(w, ov, ir, bz, idx, z);
    check({tag, "_ready_before"}, 32'(ir), 32'd1);
    if (w) begin ifb.in_valid = 1'b1; ifb.in_data = d[15:0]; ifb.in_mode = m; end
    else   begin ifa.in_valid = 1'b1; ifa.in_data = d;       ifa.in_mode = m; end
    step();
    if (w) begin ifb.in_valid = 1'b0; ifb.in_data = 16'($urandom); ifb.in_mode = 1'($urandom); end
    else   begin ifa.in_valid = 1'b0; ifa.in_data = 23'($urandom); ifa.in_mode = 1'($urandom); end
  endtask

  // out_valid must be low for cycles T+1..T+lat-1 and high at T+lat.
  task automatic expect_result(input bit w, input int lat, input logic [4:0] ei,
                               input logic ez, input string tag);
    logic ov, ir, bz, z;
    logic [4:0] idx;
    for (int k = 1; k < lat; k++) begin
      get(w, ov, ir, bz, idx, z);
      check({tag, "_wait_valid"}, 32'(ov), 32'd0);
      check({tag, "_wait_busy"}, 32'(bz), 32'd1);
      check({tag, "_wait_ready"}, 32'(ir), 32'd0);
      step();
    end
    check_outs(w, {tag, "_res"}, 1'b1, 1'b0, 1'b1, ei, ez);
  endtask

  task automatic consume(input bit w, input string tag);
    logic ov, ir, bz, z;
    logic [4:0] idx;
    if (w) ifb.out_ready = 1'b1; else ifa.out_ready = 1'b1;
    step();
    if (w) ifb.out_ready = 1'b0; else ifa.out_ready = 1'b0;
    get(w, ov, ir, bz, idx, z);
    check({tag, "_post_valid"}, 32'(ov), 32'd0);
    check({tag, "_post_ready"}, 32'(ir), 32'd1);
    check({tag, "_post_busy"}, 32'(bz), 32'd0);
  endtask

  initial begin
    nRESET = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_data = 23'h400001; ifa.in_mode = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0;         ifb.in_mode = 1'b0; ifb.out_ready = 1'b0;
    #1;
    check_outs(1'b0, "rst_a", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    check_outs(1'b1, "rst_b", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    // in_valid held through reset edges must not be taken
    step();
    step();
    check_outs(1'b0, "rst_hold", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    ifa.in_valid = 1'b0;
    nRESET = 1'b1;
    #1;
    check_outs(1'b0, "rst_rel", 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    check_outs(1'b0, "idle", 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);

    // DATA_WIDTH=23 searches
    launch(1'b0, 23'h400001, 1'b0, "msb_400001");
    expect_result(1'b0, 6, 5'd22, 1'b0, "msb_400001");
    consume(1'b0, "msb_400001");

    launch(1'b0, 23'h400001, 1'b1, "lsb_400001");
    expect_result(1'b0, 6, 5'd0, 1'b0, "lsb_400001");
    consume(1'b0, "lsb_400001");

    launch(1'b0, 23'h000100, 1'b1, "lsb_000100");
    expect_result(1'b0, 6, 5'd8, 1'b0, "lsb_000100");
    consume(1'b0, "lsb_000100");

    // zero word: result next cycle, held while busy
    launch(1'b0, 23'h000000, 1'b0, "zero");
    expect_result(1'b0, 1, 5'd0, 1'b1, "zero");
    step();
    check_outs(1'b0, "zero_hold1", 1'b1, 1'b0, 1'b1, 5'd0, 1'b1);
    step();
    check_outs(1'b0, "zero_hold2", 1'b1, 1'b0, 1'b1, 5'd0, 1'b1);
    consume(1'b0, "zero");

    // backpressure with input noise
    launch(1'b0, 23'h000050, 1'b0, "bp");
    expect_result(1'b0, 6, 5'd6, 1'b0, "bp");
    for (int k = 0; k < 10; k++) begin
      ifa.in_data  = 23'($urandom);
      ifa.in_valid = 1'($urandom);
      ifa.in_mode  = 1'($urandom);
      step();
      check_outs(1'b0, "bp_hold", 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);
    end
    ifa.in_valid = 1'b0;
    consume(1'b0, "bp");

    // reset mid-search aborts the transaction
    launch(1'b0, 23'h7FFFFF, 1'b0, "abort");
    step();
    nRESET = 1'b0;
    #1;
    check_outs(1'b0, "abort_rst", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    step();
    nRESET = 1'b1;
    #1;
    check_outs(1'b0, "abort_rel", 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      check_outs(1'b0, "abort_quiet", 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    end
    launch(1'b0, 23'h000002, 1'b0, "after_abort");
    expect_result(1'b0, 6, 5'd1, 1'b0, "after_abort");
    consume(1'b0, "after_abort");

    // DATA_WIDTH=16 searches
    launch(1'b1, 23'h008000, 1'b0, "w16_msb_8000");
    expect_result(1'b1, 5, 5'd15, 1'b0, "w16_msb_8000");
    consume(1'b1, "w16_msb_8000");

    launch(1'b1, 23'h000001, 1'b0, "w16_msb_0001");
    expect_result(1'b1, 5, 5'd0, 1'b0, "w16_msb_0001");
    consume(1'b1, "w16_msb_0001");

    launch(1'b1, 23'h008000, 1'b1, "w16_lsb_8000");
    expect_result(1'b1, 5, 5'd15, 1'b0, "w16_lsb_8000");
    consume(1'b1, "w16_lsb_8000");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
